// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: valid/ready word load, MSB-first
// serial stream advanced by shift_en, with frame start/last markers.
// Optional even-parity bit after the LSB when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] sreg;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_LEN-1:0] load_word;
  logic                 in_shift;
  logic                 cnt_zero;

  // Word as it enters the shift register; parity is fixed at capture time
`ifdef PISO_PARITY_EN
  assign load_word = {data_in, ^data_in};
`else
  assign load_word = data_in;
`endif

  assign in_shift = (state == SHIFT);
  assign cnt_zero = (cnt == '0);

  // Ready in IDLE, or on the last-bit edge so a new frame follows with no gap
  assign load_ready = !in_shift || (cnt_zero && shift_en);

  // Serial outputs decoded straight from state flops; all zero outside a frame
  assign ser_valid   = in_shift;
  assign ser_out     = in_shift && sreg[FRAME_LEN-1];
  assign frame_start = in_shift && (cnt == CNT_TOP);
  assign frame_last  = in_shift && cnt_zero;

  // Load / shift / frame-end sequencing
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            sreg  <= load_word;
            cnt   <= CNT_TOP;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (!cnt_zero) begin
              sreg <= {sreg[FRAME_LEN-2:0], 1'b0};
              cnt  <= cnt - CNT_W'(1);
            end else if (load_valid) begin
              sreg <= load_word;
              cnt  <= CNT_TOP;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer (WIDTH=8).
// Each vector drives inputs for one cycle and checks
// {ser_valid, ser_out, frame_start, frame_last, load_ready} before the edge.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  typedef struct {
    logic       lv;
    logic [7:0] d;
    logic       se;
    logic [4:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       Rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] data_in;
  logic       shift_en;
  logic       ser_out;
  logic       ser_valid;
  logic       frame_start;
  logic       frame_last;

  int tests = 0;
  int fails = 0;
  vec_t tbl[$];

  piso_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .Rst        (Rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .shift_en   (shift_en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_start(frame_start),
    .frame_last (frame_last)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {ser_valid, ser_out, frame_start, frame_last, load_ready};
  endfunction

  function automatic logic bit_of(input logic [7:0] w, input int i);
    if (i < 8) return w[7-i];
    return ^w;
  endfunction

  function automatic logic [7:0] junk(input int i);
    return 8'((i * 37) + 11);
  endfunction

  task automatic push(input logic lv, input logic [7:0] d, input logic se,
                      input logic sv, input logic so, input logic fs,
                      input logic fl, input logic lr);
    vec_t v;
    v.lv = lv; v.d = d; v.se = se; v.exp = {sv, so, fs, fl, lr};
    tbl.push_back(v);
  endtask

  task automatic push_idle_accept(input logic [7:0] w);
    push(1'b1, w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_idle();
    push(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One full frame at shift_en=1; if hold, load_valid stays high and the
  // next word is offered on the last bit, otherwise data_in is noise.
  task automatic push_frame(input logic [7:0] w, input logic hold,
                            input logic [7:0] nxt, input logic scramble);
    for (int i = 0; i < FL; i++) begin
      logic [7:0] d;
      d = (i == FL - 1) ? nxt : (scramble ? junk(i) : nxt);
      if (!hold) d = junk(i + 3);
      push(hold, d, 1'b1, 1'b1, bit_of(w, i), i == 0, i == FL - 1, i == FL - 1);
    end
  endtask

  task automatic check(input string name, input int idx,
                       input logic [4:0] got, input logic [4:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s[%0d]: got sv,so,fs,fl,lr=%b required %b", name, idx, got, want);
    end
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      load_valid = tbl[i].lv;
      data_in    = tbl[i].d;
      shift_en   = tbl[i].se;
      #1;
      check(name, i, outs(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    Rst = 1'b0; load_valid = 1'b0; data_in = 8'h00; shift_en = 1'b0;
    #2;
    check("reset_state", 0, outs(), 5'b00001);
    @(negedge clk); @(negedge clk);
    Rst = 1'b1;

    // Single word, shift_en held high
    push_idle_accept(8'hA5);
    push_frame(8'hA5, 1'b0, 8'h00, 1'b0);
    push_idle();
    run_tbl("single_a5");

    // Back-to-back frames: 8'h00 offered during the whole first frame
    push_idle_accept(8'hFF);
    push_frame(8'hFF, 1'b1, 8'h00, 1'b0);
    push_frame(8'h00, 1'b0, 8'h00, 1'b0);
    push_idle();
    run_tbl("b2b_ff_00");

    // shift_en toggling: every bit presented for two cycles
    push(1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 2 * FL; c++) begin
      int   idx;
      logic se;
      idx = (c - 1) / 2;
      se  = (c % 2) == 0;
      push(1'b0, junk(c), se, 1'b1, bit_of(8'h81, idx), idx == 0,
           idx == FL - 1, (idx == FL - 1) && se);
    end
    push_idle();
    run_tbl("throttle_81");

    // Data hold: data_in scrambled every cycle, second word only on last bit
    push_idle_accept(8'h5A);
    push_frame(8'h5A, 1'b1, 8'h96, 1'b1);
    push_frame(8'h96, 1'b0, 8'h00, 1'b0);
    push_idle();
    run_tbl("hold_5a");

    // Reset mid-frame: three bits of 8'hC3, then async reset
    push_idle_accept(8'hC3);
    for (int i = 0; i < 3; i++)
      push(1'b0, 8'h00, 1'b1, 1'b1, bit_of(8'hC3, i), i == 0, 1'b0, 1'b0);
    run_tbl("midrst_pre");
    @(negedge clk);
    load_valid = 1'b0; shift_en = 1'b1;
    #1;
    check("midrst_bit3", 0, outs(), 5'b10000);
    #1;
    Rst = 1'b0;
    #1;
    check("midrst_async_drop", 0, outs(), 5'b00001);
    load_valid = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    #1;
    check("midrst_load_ignored", 0, outs(), 5'b00001);
    load_valid = 1'b0;
    Rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_no_resume", 0, outs(), 5'b00001);
    push_idle_accept(8'h3C);
    push_frame(8'h3C, 1'b0, 8'h00, 1'b0);
    push_idle();
    run_tbl("post_rst_3c");

`ifdef PISO_PARITY_EN
    // Parity frames: 8'h07 -> parity 1, 8'h03 -> parity 0
    push_idle_accept(8'h07);
    push_frame(8'h07, 1'b0, 8'h00, 1'b0);
    push_idle();
    run_tbl("parity_07");
    push_idle_accept(8'h03);
    for (int i = 0; i < FL - 1; i++)
      push(1'b0, 8'h00, 1'b1, 1'b1, bit_of(8'h03, i), i == 0, 1'b0, 1'b0);
    run_tbl("parity_03_body");
    @(negedge clk);
    load_valid = 1'b0; shift_en = 1'b1;
    #1;
    check("parity_03_bit9", 0, outs(), 5'b10011);
    push_idle();
    run_tbl("parity_03_end");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
